mult32x32_fast_seq: RTL and testbench

- Sequential unsigned 32x32→64 multiplier built around one combinational 16x8 partial-product unit.
- Processes one 8-bit slice of a against one 16-bit half of b per cycle, and accumulates the shifted result into a 64-bit product register.
- "Fast" variant: skips partial products whose operand slice lies in an all-zero upper half, so latency is 2, 4 or 8 cycles.
- Used as a multi-cycle arithmetic unit behind a start/busy handshake.

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult32x32_fast_seq_if.sv | 11 +
 rtl/mult16x8.sv | 8 +
 rtl/mult32x32_fast_seq.sv | 54 +++++
 tb/tb_mult32x32_fast_seq.sv | 88 ++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and step-state encoding for the sequential multiplier
package mult_pkg;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;
  typedef enum logic [3:0] {
    A0B0 = 4'd0, A1B0 = 4'd1, A2B0 = 4'd2, A3B0 = 4'd3,
    A0B1 = 4'd4, A1B1 = 4'd5, A2B1 = 4'd6, A3B1 = 4'd7,
    IDLE = 4'd8
  } state_t;
endpackage

// File: rtl/mult32x32_fast_seq_if.sv
// mult32x32_fast_seq_if: start/busy handshake with operands and product (master drives start/a/b)
interface mult32x32_fast_seq_if;
  import mult_pkg::*;
  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic [PROD_W-1:0] product;
  modport master(output start, a, b, input busy, product);
  modport slave(input start, a, b, output busy, product);
endinterface

// File: rtl/mult16x8.sv
// mult16x8: combinational 16x8 unsigned multiply (x: 16b, y: 8b, z: 24b product)
module mult16x8 (
  input  logic [15:0] x,
  input  logic [7:0]  y,
  output logic [23:0] z
);
  assign z = 24'(x) * 24'(y);
endmodule

// File: rtl/mult32x32_fast_seq.sv
// mult32x32_fast_seq: sequential 32x32->64 multiplier, one 16x8 partial product per cycle, skipping zero upper halves (clk, reset active-low async, bus slave)
module mult32x32_fast_seq
  import mult_pkg::*;
(
  input logic clk,
  input logic reset,
  mult32x32_fast_seq_if.slave bus
);
  state_t state, nxt;
  logic [OP_W-1:0] ar, br;
  logic a_hi_z, b_hi_z, j;
  logic [1:0] i;
  logic [5:0] sh;
  logic [BYTE_W-1:0] a_byte;
  logic [HALF_W-1:0] b_half;
  logic [23:0] pp;
  assign a_hi_z = ~|ar[OP_W-1:HALF_W];
  assign b_hi_z = ~|br[OP_W-1:HALF_W];
  // state encoding doubles as the step index: bits [1:0] = a byte, bit 2 = b half
  assign i = state[1:0];
  assign j = state[2];
  assign a_byte = ar[{i, 3'b000} +: BYTE_W];
  assign b_half = br[{j, 4'b0000} +: HALF_W];
  assign sh = {1'b0, i, 3'b000} + {1'b0, j, 4'b0000};
  mult16x8 u_mul (.x(b_half), .y(a_byte), .z(pp));
  assign bus.busy = state != IDLE;
  always_comb begin
    nxt = state == A0B0 ? A1B0 :
          state == A1B0 ? (!a_hi_z ? A2B0 : !b_hi_z ? A0B1 : IDLE) :
          state == A2B0 ? A3B0 :
          state == A3B0 ? (b_hi_z ? IDLE : A0B1) :
          state == A0B1 ? A1B1 :
          state == A1B1 ? (a_hi_z ? IDLE : A2B1) :
          state == A2B1 ? A3B1 : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ar          <= '0;
      br          <= '0;
      bus.product <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        ar          <= bus.a;
        br          <= bus.b;
        bus.product <= '0;
        state       <= A0B0;
      end
    end else begin
      bus.product <= bus.product + (PROD_W'(pp) << sh);
      state       <= nxt;
    end
  end
endmodule

// File: tb/tb_mult32x32_fast_seq.sv
// tb_mult32x32_fast_seq: directed-vector self-checking bench for mult32x32_fast_seq
module tb_mult32x32_fast_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  mult32x32_fast_seq_if mif();
  mult32x32_fast_seq dut (.clk(clk), .reset(reset), .bus(mif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1;
    mif.a = a;
    mif.b = b;
    @(negedge clk);
  endtask
  task automatic finish(input string tag, input int n0, input int exp_n, input logic [63:0] exp_p);
    int n = n0;
    mif.start = 1'b0;
    while (mif.busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "_busy"}, 64'(mif.busy), 64'd0);
    chk({tag, "_prod"}, mif.product, exp_p);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input int exp_n, input logic [63:0] exp_p);
    launch(a, b);
    chk({tag, "_rise"}, 64'(mif.busy), 64'd1);
    finish(tag, 0, exp_n, exp_p);
  endtask
  initial begin
    mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;
    repeat (4) @(negedge clk);
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_prod", mif.product, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    run("dec", 32'd212533061, 32'd342824687, 8, 64'd72861580114476907);
    run("hi", 32'h0CAA0000, 32'h146F0000, 8, 64'h0102C5B6_00000000);
    run("lo", 32'h00001234, 32'h00005678, 2, 64'h00000000_06260060);
    repeat (3) @(negedge clk);
    chk("hold", mif.product, 64'h00000000_06260060);
    run("bz", 32'hFFFFFFFF, 32'h0000FFFF, 4, 64'h0000FFFE_FFFF0001);
    run("az", 32'h0000FFFF, 32'hFFFFFFFF, 4, 64'h0000FFFE_FFFF0001);
    launch(32'h0CAA0000, 32'h146F0000);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    mif.start = 1'b1;
    mif.a = 32'hFFFFFFFF;
    mif.b = 32'h00000005;
    repeat (2) @(negedge clk);
    finish("ign", 4, 8, 64'h0102C5B6_00000000);
    launch(32'd212533061, 32'd342824687);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(mif.busy), 64'd0);
    chk("arst_prod", mif.product, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("post", 32'h00001234, 32'h00005678, 2, 64'h00000000_06260060);
    run("zero", 32'd0, 32'd0, 2, 64'd0);
    launch(32'h00001234, 32'h00005678);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_idle", 64'(mif.busy), 64'd0);
    chk("b2b_first", mif.product, 64'h00000000_06260060);
    launch(32'hFFFFFFFF, 32'h0000FFFF);
    chk("b2b_busy", 64'(mif.busy), 64'd1);
    chk("b2b_clear", mif.product, 64'd0);
    finish("b2b", 0, 4, 64'h0000FFFE_FFFF0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
